uart_tx_feeder: RTL and testbench

//  Upstream stage of the UART transmitter. Buffers bytes from the system side in a

---
 rtl/uart_tx_feeder.sv | 115 +++++++++++
 tb/tb_uart_tx_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Feeds the UART transmitter from a synchronous byte FIFO. Each byte is launched
// with a one-cycle Data_Valid and popped only when TX_BUSY acknowledges it.
module uart_tx_feeder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned         TW       = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0]       TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [TW-1:0]         tmo;
  logic [TW-1:0]         tmo_inc;
  state_t                state;
  logic                  wr_ok;
  logic                  pop;
  logic [ADDR_WIDTH:0]   count_nxt;

  // FULL is the registered pre-edge flag, so a write racing a pop at full is dropped.
  always_comb begin
    wr_ok     = WR_EN && !FULL;
    pop       = (state == WAIT_ACK) && TX_BUSY;
    tmo_inc   = tmo + 1'b1;
    count_nxt = COUNT;
    if (wr_ok && !pop)
      count_nxt = COUNT + 1'b1;
    else if (!wr_ok && pop)
      count_nxt = COUNT - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_ok)
      mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      COUNT      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      OVERFLOW   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      tmo        <= '0;
      state      <= IDLE;
    end else begin
      OVERFLOW   <= WR_EN && FULL;
      Data_Valid <= 1'b0;
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      COUNT <= count_nxt;
      FULL  <= (count_nxt == DEPTH_C);
      EMPTY <= (count_nxt == '0);

      case (state)
        IDLE: begin
          if (!EMPTY && !TX_BUSY) begin
            P_DATA     <= mem[rd_ptr];
            Data_Valid <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Retry fires as the counter reaches ACK_TIMEOUT-1; P_DATA is left untouched.
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (tmo_inc == TMO_LAST) begin
            Data_Valid <= 1'b1;
            state      <= LAUNCH;
          end else begin
            tmo <= tmo_inc;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: drives TX_BUSY as a simple transmitter model
// and compares every observation against hand-computed values.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       tx_busy;
  logic [7:0] p_data;
  logic       data_valid;

  int total = 0;
  int bad   = 0;

  uart_tx_feeder #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .ADDR_WIDTH (3),
    .ACK_TIMEOUT(4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .WR_DATA   (wr_data),
    .WR_EN     (wr_en),
    .FULL      (full),
    .EMPTY     (empty),
    .COUNT     (count),
    .OVERFLOW  (overflow),
    .TX_BUSY   (tx_busy),
    .P_DATA    (p_data),
    .Data_Valid(data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_dv"}, data_valid, 1'b1);
    check({tag, "_pdata"}, p_data, exp);
  endtask

  // Busy rises 2 cycles after the launch, pop lands on the busy-rise edge.
  task automatic ack_frame(input string tag, input logic [3:0] exp_count);
    tick();
    check({tag, "_dv_low"}, data_valid, 1'b0);
    tick();
    tx_busy = 1'b1;
    tick();
    check({tag, "_count_pop"}, count, exp_count);
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic serve(input string tag, input logic [7:0] exp, input logic [3:0] exp_count);
    wait_dv(tag, exp);
    ack_frame(tag, exp_count);
  endtask

  task automatic no_dv(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (data_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0;
    tick();
    check("rst_dv", data_valid, 1'b0);
    check("rst_pdata", p_data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    rst = 1'b0;
    tick();

    // 1: single byte, exact launch latency, 11-cycle busy
    write_byte(8'hA5);
    check("t1_count1", count, 4'd1);
    check("t1_dv_early", data_valid, 1'b0);
    tick();
    check("t1_dv", data_valid, 1'b1);
    check("t1_pdata", p_data, 8'hA5);
    tick();
    check("t1_dv_once", data_valid, 1'b0);
    tick();
    tx_busy = 1'b1;
    tick();
    check("t1_count0", count, 4'd0);
    check("t1_empty", empty, 1'b1);
    no_dv("t1_no_dv_busy", 10);
    tx_busy = 1'b0;
    no_dv("t1_no_dv_idle", 6);
    check("t1_pdata_hold", p_data, 8'hA5);

    // 2: fill, overflow, in-order drain with pointer wrap
    tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    check("t2_full", full, 1'b1);
    check("t2_count8", count, 4'd8);
    write_byte(8'hFF);
    check("t2_ovf", overflow, 1'b1);
    check("t2_count_ovf", count, 4'd8);
    check("t2_full_ovf", full, 1'b1);
    tick();
    check("t2_ovf_pulse", overflow, 1'b0);
    tx_busy = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) serve("t2_frame", 8'(i), 4'(8 - i));
    check("t2_empty", empty, 1'b1);
    no_dv("t2_no_extra", 8);

    // 3: first launch ignored, retry after ACK_TIMEOUT cycles
    write_byte(8'h5A);
    wait_dv("t3_first", 8'h5A);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_gap_dv", data_valid, 1'b0);
    end
    tick();
    check("t3_retry_dv", data_valid, 1'b1);
    check("t3_retry_pdata", p_data, 8'h5A);
    check("t3_count_held", count, 4'd1);
    ack_frame("t3_ack", 4'd0);

    // 4: write coincides with pop at COUNT=3
    tx_busy = 1'b1;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    check("t4_count3", count, 4'd3);
    tx_busy = 1'b0;
    wait_dv("t4_f0", 8'h11);
    tick();
    tick();
    tx_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h44;
    tick();
    wr_en = 1'b0;
    check("t4_count_same", count, 4'd3);
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
    serve("t4_f1", 8'h22, 4'd2);
    serve("t4_f2", 8'h33, 4'd1);
    serve("t4_f3", 8'h44, 4'd0);

    // 5: reset during WAIT_DONE
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h61 + i));
    tx_busy = 1'b0;
    wait_dv("t5_f0", 8'h61);
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    check("t5_count5", count, 4'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_busy = 1'b0;
    check("t5_dv", data_valid, 1'b0);
    check("t5_pdata", p_data, 8'h00);
    check("t5_count", count, 4'd0);
    check("t5_empty", empty, 1'b1);
    no_dv("t5_no_dv", 10);

    // 6: busy held from reset blocks launch
    rst = 1'b1; tx_busy = 1'b1;
    tick();
    rst = 1'b0;
    write_byte(8'h3C);
    no_dv("t6_blocked", 6);
    check("t6_count", count, 4'd1);
    tx_busy = 1'b0;
    tick();
    check("t6_dv", data_valid, 1'b1);
    check("t6_pdata", p_data, 8'h3C);
    ack_frame("t6_ack", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
